mesh_fetcher: RTL and testbench
===============================

# mesh_fetcher

Parametrised triangle fetcher for the 3D pipeline. On a start pulse it walks an indexed mesh in external facet and vertex ROMs and emits one homogeneous triangle per facet. Each triangle is 3 vertices × (x, y, z, w) and is handed to the transform stage over a ready/valid handshake. It generalises the fixed-object vertex getter with:
- configurable widths, ROM latency and index base;
- a runtime facet/vertex count;
- backpressure, continuous loop mode, and out-of-range index rejection.

## Interface
Parameters:
- COORD_WIDTH, 32, width of one coordinate.
- INDEX_WIDTH, 16, width of one facet index and of both ROM address buses.
- ROM_LATENCY, 2, cycles from address driven to data valid (1..4).
- INDEX_BASE, 1, value of the first vertex index in the facet ROM (1 = OBJ style).
- ONE_VALUE, 1, constant placed in the w row.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset, asynchronous, active-low.
- start_in  input  1  begin a pass at facet 0; ignored while busy_out=1.
- loop_in  input  1  sampled at end of pass; 1 = restart automatically.
- num_facets_in  input  INDEX_WIDTH  facets in object; sampled at start.
- num_vertices_in  input  INDEX_WIDTH  vertices in object; sampled at start.
- facet_addr_out  output  INDEX_WIDTH  facet ROM address.
- facet_data_in  input  3*INDEX_WIDTH  {f1,f2,f3}, f1 in MSBs.
- vertex_addr_out  output  INDEX_WIDTH  vertex ROM address.
- vertex_data_in  input  3*COORD_WIDTH  {x,y,z}, x in MSBs.
- tri_out  output  [3:0][2:0] × COORD_WIDTH  rows: [3]=x, [2]=y, [1]=z, [0]=w; column k = vertex k.
- valid_out  output  1  triangle available.
- ready_in  input  1  downstream accepts.
- last_out  output  1  qualifies valid_out; current triangle is the last facet of the pass.
- busy_out  output  1  a pass is in progress.
- obj_done_out  output  1  one-cycle pulse at end of pass.
- skip_count_out  output  INDEX_WIDTH  facets rejected this pass; cleared at start.

## Operation
- States: IDLE, FREQ, FWAIT, VREQ, VWAIT, OUT.
- IDLE → FREQ on start_in when num_facets_in ≠ 0. The facet counter is cleared.
  - With num_facets_in = 0: obj_done_out pulses the next cycle, busy_out stays 0, and no triangle is emitted.
- FREQ drives facet_addr_out = facet counter, then enters FWAIT.
- At the end of FWAIT (ROM_LATENCY cycles) the indices are latched.
  - An index is bad if it is < INDEX_BASE, or if (index − INDEX_BASE) ≥ num_vertices_in.
  - Any bad index: the facet is skipped, skip_count_out increments (saturating), and the block advances to the next facet with no output.
- VREQ drives vertex_addr_out = fk − INDEX_BASE for k = 0, 1, 2 on three consecutive cycles.
- VWAIT captures vertex_data_in into column k exactly ROM_LATENCY cycles after address k. Row 0 of each column is ONE_VALUE.
- OUT holds valid_out = 1 and tri_out stable until ready_in = 1.
- After the handshake, the facet counter increments and the block returns to FREQ, or ends the pass when the counter reaches num_facets−1.
- End of pass (last handshake, or last facet skipped):
  - obj_done_out pulses for 1 cycle.
  - If loop_in = 1: FREQ at facet 0 next cycle, num_* re-sampled, skip count cleared, busy_out stays 1.
  - Otherwise: IDLE with busy_out = 0.
- Address outputs hold their last value when not driven by a request.
- Reset (async assert, any state): IDLE. valid_out, last_out, busy_out, obj_done_out, skip_count_out, tri_out, facet_addr_out and vertex_addr_out all go to 0.

## Timing
- Let FREQ be cycle t.
  - facet_data_in is sampled at t+L.
  - vertex address k is driven at t+L+1+k.
  - vertex data k is sampled at t+2L+1+k.
  - valid_out rises at t+2L+4 (L = ROM_LATENCY; t+8 for L=2).
- With ready_in held high, the throughput is one triangle per 2L+5 cycles. The next FREQ is the cycle after the handshake.
- A skipped facet costs L+1 cycles. The next FREQ is at t+L+1.
- obj_done_out is asserted in the cycle after the final handshake or skip.
- start_in is accepted only in IDLE. A start in the same cycle as the obj_done_out pulse is ignored; start in the following cycle.
- valid_out never deasserts without a handshake, except on reset.

## Test plan
- L=2, two facets {1,2,3},{3,2,4}, vertices v_i=(10i, 10i+1, 10i+2), ready_in=1 → valid_out at start+9 with columns (10,11,12,1),(20,21,22,1),(30,31,32,1). Second triangle follows 2L+5 = 9 cycles later with last_out=1, then obj_done_out pulses once.
- Same mesh, ready_in low for 20 cycles on the first triangle → valid_out and tri_out held unchanged; no extra ROM addresses issued; completes normally once ready_in rises.
- Facet {0,1,2} with INDEX_BASE=1, plus facet {1,2,9} with num_vertices_in=4 → both skipped, skip_count_out=2, no valid_out, obj_done_out pulses.
- num_facets_in=0 with a start → obj_done_out pulses the next cycle; busy_out stays 0.
- loop_in=1, 1-facet mesh → the triangle repeats indefinitely with obj_done_out once per pass; dropping loop_in ends in IDLE after the current pass.
- rst_in asserted while in VWAIT → all outputs 0 immediately; after release, a new start_in produces the correct first triangle.

Source files
------------

// File: rtl/mesh_fetcher.sv
`default_nettype none
// ============================================================================
// mesh_fetcher : walks an indexed mesh in facet/vertex ROMs and emits one
//                homogeneous triangle per facet over a ready/valid handshake.
// Revision     : 1.0
// ============================================================================
module mesh_fetcher #(
   parameter int COORD_WIDTH = 32,
   parameter int INDEX_WIDTH = 16,
   parameter int ROM_LATENCY = 2,
   parameter int INDEX_BASE  = 1,
   parameter int ONE_VALUE   = 1
) (
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic                             start_in,
   input  logic                             loop_in,
   input  logic [INDEX_WIDTH-1:0]           num_facets_in,
   input  logic [INDEX_WIDTH-1:0]           num_vertices_in,
   output logic [INDEX_WIDTH-1:0]           facet_addr_out,
   input  logic [3*INDEX_WIDTH-1:0]         facet_data_in,
   output logic [INDEX_WIDTH-1:0]           vertex_addr_out,
   input  logic [3*COORD_WIDTH-1:0]         vertex_data_in,
   output logic [3:0][2:0][COORD_WIDTH-1:0] tri_out,
   output logic                             valid_out,
   input  logic                             ready_in,
   output logic                             last_out,
   output logic                             busy_out,
   output logic                             obj_done_out,
   output logic [INDEX_WIDTH-1:0]           skip_count_out
);

   localparam logic [2:0]             LAT  = 3'(ROM_LATENCY);
   localparam logic [INDEX_WIDTH-1:0] BASE = INDEX_WIDTH'(INDEX_BASE);
   localparam logic [COORD_WIDTH-1:0] ONE  = COORD_WIDTH'(ONE_VALUE);

   typedef enum logic [2:0] {IDLE, FREQ, FWAIT, VREQ, VWAIT, OUT} state_t;

   state_t                       state;
   logic [INDEX_WIDTH-1:0]       facet_cnt;
   logic [INDEX_WIDTH-1:0]       num_facets;
   logic [INDEX_WIDTH-1:0]       num_vertices;
   logic [1:0][INDEX_WIDTH-1:0]  pend_addr;
   logic [2:0]                   wait_cnt;
   logic [2:0]                   vtx_cnt;
   logic [2:0][INDEX_WIDTH-1:0]  fidx;
   logic [2:0]                   bad_idx;
   logic                         fwait_done;
   logic                         skip;
   logic                         handshake;
   logic                         facet_end;
   logic                         last_facet;
   logic                         capture;
   logic [1:0]                   cap_col;
   logic [COORD_WIDTH-1:0]       vx, vy, vz;

   assign fidx[0] = facet_data_in[3*INDEX_WIDTH-1 -: INDEX_WIDTH];
   assign fidx[1] = facet_data_in[2*INDEX_WIDTH-1 -: INDEX_WIDTH];
   assign fidx[2] = facet_data_in[INDEX_WIDTH-1:0];

   assign vx = vertex_data_in[3*COORD_WIDTH-1 -: COORD_WIDTH];
   assign vy = vertex_data_in[2*COORD_WIDTH-1 -: COORD_WIDTH];
   assign vz = vertex_data_in[COORD_WIDTH-1:0];

   always_comb begin
      bad_idx = '0;
      for (int k = 0; k < 3; k++)
         bad_idx[k] = (fidx[k] < BASE) || ((fidx[k] - BASE) >= num_vertices);
   end

   assign fwait_done = (state == FWAIT) && (wait_cnt == LAT);
   assign skip       = fwait_done && (|bad_idx);
   assign handshake  = (state == OUT) && ready_in;
   assign facet_end  = skip || handshake;
   assign last_facet = (facet_cnt == num_facets - INDEX_WIDTH'(1));

   // Vertex reads are pipelined: column k lands LAT cycles after its address,
   // which may overlap the remaining address cycles when LAT is small.
   assign capture = ((state == VREQ) || (state == VWAIT)) &&
                    (vtx_cnt >= LAT) && (vtx_cnt <= LAT + 3'd2);
   assign cap_col = 2'(vtx_cnt - LAT);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state           <= IDLE;
         facet_cnt       <= '0;
         num_facets      <= '0;
         num_vertices    <= '0;
         pend_addr       <= '0;
         wait_cnt        <= '0;
         vtx_cnt         <= '0;
         facet_addr_out  <= '0;
         vertex_addr_out <= '0;
         tri_out         <= '0;
         valid_out       <= 1'b0;
         last_out        <= 1'b0;
         busy_out        <= 1'b0;
         obj_done_out    <= 1'b0;
         skip_count_out  <= '0;
      end else begin
         obj_done_out <= 1'b0;

         if (capture) begin
            tri_out[3][cap_col] <= vx;
            tri_out[2][cap_col] <= vy;
            tri_out[1][cap_col] <= vz;
            tri_out[0][cap_col] <= ONE;
         end

         case (state)
            IDLE: begin
               // The cycle carrying obj_done_out still belongs to the old pass.
               if (start_in && !obj_done_out) begin
                  skip_count_out <= '0;
                  if (num_facets_in != '0) begin
                     state          <= FREQ;
                     busy_out       <= 1'b1;
                     facet_cnt      <= '0;
                     facet_addr_out <= '0;
                     num_facets     <= num_facets_in;
                     num_vertices   <= num_vertices_in;
                  end else begin
                     obj_done_out <= 1'b1;
                  end
               end
            end
            FREQ: begin
               wait_cnt <= 3'd1;
               state    <= FWAIT;
            end
            FWAIT: begin
               if (!fwait_done) begin
                  wait_cnt <= wait_cnt + 3'd1;
               end else if (bad_idx == 3'b000) begin
                  vertex_addr_out <= fidx[0] - BASE;
                  pend_addr[0]    <= fidx[1] - BASE;
                  pend_addr[1]    <= fidx[2] - BASE;
                  vtx_cnt         <= '0;
                  state           <= VREQ;
               end else if (skip_count_out != '1) begin
                  skip_count_out <= skip_count_out + INDEX_WIDTH'(1);
               end
            end
            VREQ: begin
               vtx_cnt <= vtx_cnt + 3'd1;
               if (vtx_cnt == 3'd0)
                  vertex_addr_out <= pend_addr[0];
               else if (vtx_cnt == 3'd1)
                  vertex_addr_out <= pend_addr[1];
               else
                  state <= VWAIT;
            end
            VWAIT: begin
               vtx_cnt <= vtx_cnt + 3'd1;
               if (vtx_cnt == LAT + 3'd2) begin
                  state     <= OUT;
                  valid_out <= 1'b1;
                  last_out  <= last_facet;
               end
            end
            OUT: begin
               if (ready_in) begin
                  valid_out <= 1'b0;
                  last_out  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         // Facet retirement (handshake or skip) overrides the per-state next state.
         if (facet_end) begin
            if (last_facet) begin
               obj_done_out <= 1'b1;
               if (loop_in && (num_facets_in != '0)) begin
                  state          <= FREQ;
                  facet_cnt      <= '0;
                  facet_addr_out <= '0;
                  num_facets     <= num_facets_in;
                  num_vertices   <= num_vertices_in;
                  skip_count_out <= '0;
               end else begin
                  state    <= IDLE;
                  busy_out <= 1'b0;
               end
            end else begin
               state          <= FREQ;
               facet_cnt      <= facet_cnt + INDEX_WIDTH'(1);
               facet_addr_out <= facet_cnt + INDEX_WIDTH'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mesh_fetcher.sv
`default_nettype none
// ============================================================================
// tb_mesh_fetcher : randomized and directed bench for mesh_fetcher with ROM
//                   models and a facet-level triangle reference model.
// Revision        : 1.0
// ============================================================================
module tb_mesh_fetcher;

   localparam int CW   = 32;
   localparam int IW   = 16;
   localparam int LAT  = 2;
   localparam int BASE = 1;

   typedef logic [3:0][2:0][CW-1:0] tri_t;
   typedef struct {
      tri_t t;
      logic last;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_in, start_in, loop_in, ready_in;
   logic [IW-1:0]   num_facets_in, num_vertices_in;
   logic [IW-1:0]   facet_addr_out, vertex_addr_out, skip_count_out;
   logic [3*IW-1:0] facet_data_in;
   logic [3*CW-1:0] vertex_data_in;
   tri_t            tri_out;
   logic            valid_out, last_out, busy_out, obj_done_out;

   logic [IW-1:0]   from [16][3];
   logic [CW-1:0]   vrx [16];
   logic [CW-1:0]   vry [16];
   logic [CW-1:0]   vrz [16];
   logic [IW-1:0]   fa_d1, fa_d2, va_d1, va_d2;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   done_cnt = 0;

   mesh_fetcher #(
      .COORD_WIDTH (CW),
      .INDEX_WIDTH (IW),
      .ROM_LATENCY (LAT),
      .INDEX_BASE  (BASE),
      .ONE_VALUE   (1)
   ) dut (
      .clk_in          (clk),
      .rst_in          (rst_in),
      .start_in        (start_in),
      .loop_in         (loop_in),
      .num_facets_in   (num_facets_in),
      .num_vertices_in (num_vertices_in),
      .facet_addr_out  (facet_addr_out),
      .facet_data_in   (facet_data_in),
      .vertex_addr_out (vertex_addr_out),
      .vertex_data_in  (vertex_data_in),
      .tri_out         (tri_out),
      .valid_out       (valid_out),
      .ready_in        (ready_in),
      .last_out        (last_out),
      .busy_out        (busy_out),
      .obj_done_out    (obj_done_out),
      .skip_count_out  (skip_count_out)
   );

   initial forever #5 clk = ~clk;
   initial forever @(posedge clk) cyc++;

   // ROMs with a two-cycle address-to-data latency
   always @(posedge clk) begin
      fa_d1 <= facet_addr_out;
      fa_d2 <= fa_d1;
      va_d1 <= vertex_addr_out;
      va_d2 <= va_d1;
   end
   assign facet_data_in  = {from[fa_d2[3:0]][0], from[fa_d2[3:0]][1], from[fa_d2[3:0]][2]};
   assign vertex_data_in = {vrx[va_d2[3:0]], vry[va_d2[3:0]], vrz[va_d2[3:0]]};

   task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: one triangle per facet whose three indices are all in range.
   task automatic model_pass(input int nf, input int nv, output int skips);
      tri_t t;
      exp_t e;
      logic bad;
      int   ix;
      skips = 0;
      for (int i = 0; i < nf; i++) begin
         bad = 1'b0;
         for (int k = 0; k < 3; k++) begin
            ix = int'(from[i][k]);
            if (ix < BASE || ix - BASE >= nv) bad = 1'b1;
         end
         if (bad) begin
            skips++;
         end else begin
            for (int k = 0; k < 3; k++) begin
               ix = int'(from[i][k]) - BASE;
               t[3][k] = vrx[ix];
               t[2][k] = vry[ix];
               t[1][k] = vrz[ix];
               t[0][k] = CW'(1);
            end
            e.t    = t;
            e.last = (i == nf - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   // Scoreboard and hold monitor, sampled mid-cycle
   initial begin
      logic          prev_stall = 1'b0;
      tri_t          prev_tri;
      logic [IW-1:0] prev_fa, prev_va;
      exp_t          e;
      forever begin
         @(negedge clk);
         if (!rst_in) begin
            prev_stall = 1'b0;
            exp_q.delete();
         end else begin
            if (prev_stall) begin
               check("hold_valid", 384'(valid_out), 384'(1));
               check("hold_tri", tri_out, prev_tri);
               check("hold_faddr", 384'(facet_addr_out), 384'(prev_fa));
               check("hold_vaddr", 384'(vertex_addr_out), 384'(prev_va));
            end
            if (valid_out && ready_in) begin
               if (exp_q.size() == 0) begin
                  check("extra_tri", 384'(1), 384'(0));
               end else begin
                  e = exp_q.pop_front();
                  check("tri", tri_out, e.t);
                  check("last", 384'(last_out), 384'(e.last));
               end
            end
            if (obj_done_out) done_cnt++;
            prev_stall = valid_out && !ready_in;
            prev_tri   = tri_out;
            prev_fa    = facet_addr_out;
            prev_va    = vertex_addr_out;
         end
      end
   end

   task automatic wait_done(input bit rmode, input int bound, output int d);
      bit got = 1'b0;
      d = -1;
      for (int i = 0; i < bound && !got; i++) begin
         @(posedge clk); #1;
         if (rmode) ready_in = ($urandom_range(0, 3) != 0);
         if (obj_done_out) begin
            got = 1'b1;
            d   = cyc;
         end
      end
      if (!got) check("done_timeout", 384'(0), 384'(1));
   endtask

   task automatic wait_valid(input int bound, output int v);
      bit got = 1'b0;
      v = -1;
      for (int i = 0; i < bound && !got; i++) begin
         @(posedge clk); #1;
         if (valid_out) begin
            got = 1'b1;
            v   = cyc;
         end
      end
      if (!got) check("valid_timeout", 384'(0), 384'(1));
   endtask

   task automatic pulse_start(input int nf, input int nv, output int s);
      @(posedge clk); #1;
      num_facets_in   = IW'(nf);
      num_vertices_in = IW'(nv);
      start_in        = 1'b1;
      s               = cyc;
      @(posedge clk); #1;
      start_in = 1'b0;
   endtask

   task automatic end_checks(input int sk);
      check("skip_count", 384'(skip_count_out), 384'(sk));
      check("busy_at_done", 384'(busy_out), 384'(0));
      check("queue_drained", 384'(exp_q.size()), 384'(0));
      @(posedge clk); #1;
      check("done_pulse_width", 384'(obj_done_out), 384'(0));
   endtask

   task automatic run_pass(input int nf, input int nv, input bit rmode, output int s, output int d);
      int sk;
      model_pass(nf, nv, sk);
      if (!rmode) ready_in = 1'b1;
      pulse_start(nf, nv, s);
      wait_done(rmode, 3000, d);
      end_checks(sk);
   endtask

   task automatic load_demo();
      from[0][0] = IW'(1); from[0][1] = IW'(2); from[0][2] = IW'(3);
      from[1][0] = IW'(3); from[1][1] = IW'(2); from[1][2] = IW'(4);
      for (int j = 0; j < 16; j++) begin
         vrx[j] = CW'(10 * (j + 1));
         vry[j] = CW'(10 * (j + 1) + 1);
         vrz[j] = CW'(10 * (j + 1) + 2);
      end
   endtask

   initial begin
      int   s, d, v1, v2, d1, d2, d3, sk, dc0, nf, nv;
      tri_t spec_tri;
      logic [IW-1:0] fa_hold, va_hold;

      rst_in = 1'b0; start_in = 1'b0; loop_in = 1'b0; ready_in = 1'b1;
      num_facets_in = '0; num_vertices_in = '0;
      for (int i = 0; i < 16; i++)
         for (int k = 0; k < 3; k++) from[i][k] = '0;
      load_demo();
      repeat (3) @(posedge clk);
      #1;
      check("rst_flags", 384'({valid_out, last_out, busy_out, obj_done_out}), 384'(0));
      check("rst_tri", tri_out, '0);
      check("rst_addr", 384'({facet_addr_out, vertex_addr_out}), 384'(0));
      check("rst_skip", 384'(skip_count_out), 384'(0));
      @(posedge clk); #1 rst_in = 1'b1;

      // Demo mesh: first valid at start+9, next 2L+5 later with last
      model_pass(2, 4, sk);
      pulse_start(2, 4, s);
      wait_valid(60, v1);
      check("first_latency", 384'(v1 - s), 384'(9));
      for (int k = 0; k < 3; k++) begin
         spec_tri[3][k] = CW'(10 * (k + 1));
         spec_tri[2][k] = CW'(10 * (k + 1) + 1);
         spec_tri[1][k] = CW'(10 * (k + 1) + 2);
         spec_tri[0][k] = CW'(1);
      end
      check("demo_tri0", tri_out, spec_tri);
      check("demo_last0", 384'(last_out), 384'(0));
      wait_valid(60, v2);
      check("tri_period", 384'(v2 - v1), 384'(2 * LAT + 5));
      check("demo_last1", 384'(last_out), 384'(1));
      wait_done(1'b0, 60, d);
      check("done_after_last", 384'(d - v2), 384'(1));
      end_checks(sk);

      // Backpressure on the first triangle
      model_pass(2, 4, sk);
      ready_in = 1'b0;
      pulse_start(2, 4, s);
      wait_valid(60, v1);
      fa_hold = facet_addr_out;
      va_hold = vertex_addr_out;
      repeat (20) @(posedge clk);
      #1;
      check("stall_valid", 384'(valid_out), 384'(1));
      check("stall_addr", 384'({facet_addr_out, vertex_addr_out}), 384'({fa_hold, va_hold}));
      ready_in = 1'b1;
      wait_done(1'b0, 100, d);
      end_checks(sk);

      // Out-of-range indices: both facets skipped, L+1 cycles each
      from[0][0] = IW'(0); from[0][1] = IW'(1); from[0][2] = IW'(2);
      from[1][0] = IW'(1); from[1][1] = IW'(2); from[1][2] = IW'(9);
      run_pass(2, 4, 1'b0, s, d);
      check("skip_timing", 384'(d - s), 384'(2 * (LAT + 1) + 1));

      // Empty object, and start coinciding with obj_done is ignored
      pulse_start(0, 4, s);
      check("empty_done", 384'(obj_done_out), 384'(1));
      check("empty_busy", 384'(busy_out), 384'(0));
      num_facets_in = IW'(1);
      start_in      = 1'b1;
      @(posedge clk); #1;
      start_in = 1'b0;
      check("start_in_done_ignored", 384'({busy_out, obj_done_out}), 384'(0));
      repeat (12) @(posedge clk);
      #1;
      check("still_idle", 384'({busy_out, valid_out}), 384'(0));

      // Loop mode, one facet per pass
      load_demo();
      from[0][0] = IW'(2); from[0][1] = IW'(3); from[0][2] = IW'(1);
      for (int p = 0; p < 4; p++) model_pass(1, 3, sk);
      dc0     = done_cnt;
      loop_in = 1'b1;
      pulse_start(1, 3, s);
      wait_done(1'b0, 60, d1);
      wait_done(1'b0, 60, d2);
      check("loop_busy", 384'(busy_out), 384'(1));
      wait_done(1'b0, 60, d3);
      loop_in = 1'b0;
      check("loop_period1", 384'(d2 - d1), 384'(2 * LAT + 5));
      check("loop_period2", 384'(d3 - d2), 384'(2 * LAT + 5));
      wait_done(1'b0, 60, d);
      @(negedge clk);
      check("loop_done_count", 384'(done_cnt - dc0), 384'(4));
      check("loop_queue", 384'(exp_q.size()), 384'(0));
      check("loop_end_idle", 384'(busy_out), 384'(0));

      // Reset while waiting on vertex data
      load_demo();
      model_pass(2, 4, sk);
      pulse_start(2, 4, s);
      repeat (6) @(posedge clk);
      #1;
      check("pre_rst_vaddr", 384'(vertex_addr_out), 384'(2));
      check("pre_rst_busy", 384'(busy_out), 384'(1));
      rst_in = 1'b0;
      #1;
      check("async_rst_flags", 384'({valid_out, last_out, busy_out, obj_done_out}), 384'(0));
      check("async_rst_addr", 384'({facet_addr_out, vertex_addr_out, skip_count_out}), 384'(0));
      check("async_rst_tri", tri_out, '0);
      repeat (2) @(posedge clk);
      #1 rst_in = 1'b1;
      run_pass(2, 4, 1'b0, s, d);

      // Randomized meshes with random backpressure
      for (int r = 0; r < 8; r++) begin
         nf = $urandom_range(1, 8);
         nv = $urandom_range(1, 12);
         for (int i = 0; i < 16; i++)
            for (int k = 0; k < 3; k++)
               from[i][k] = ($urandom_range(0, 4) == 0) ? IW'($urandom_range(0, nv + 2))
                                                        : IW'($urandom_range(1, nv));
         for (int j = 0; j < 16; j++) begin
            vrx[j] = $urandom;
            vry[j] = $urandom;
            vrz[j] = $urandom;
         end
         run_pass(nf, nv, 1'b1, s, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before timeout");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
